// File: rtl/imem_loader.sv
// Byte-stream program loader: header N, then N 16-bit words (high byte first), written to instruction memory.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int WORD_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {IDLE, HDR, HI, LO, WRITE, CHK, DONE, ERR} state_t;

  state_t            state;
  logic [ADDR_W:0]   n;
  logic [ADDR_W-1:0] idx;
  logic [7:0]        hi;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  logic xfer;
  assign in_ready = (state == HDR) || (state == HI) || (state == LO) || (state == CHK);
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
      n          <= '0;
      idx        <= '0;
      hi         <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= HDR;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
            idx        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
          end
        end
        HDR: begin
          if (xfer) begin
            if (in_data == 8'd0 || {1'b0, in_data} > 9'(DEPTH)) begin
              state <= ERR;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              n     <= (ADDR_W+1)'(in_data);
              state <= HI;
            end
          end
        end
        HI: begin
          if (xfer) begin
            hi    <= in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum  <= csum ^ in_data;
`endif
            state <= LO;
          end
        end
        LO: begin
          if (xfer) begin
            mem_wdata <= {hi, in_data};
            mem_addr  <= idx;
            mem_we    <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum      <= csum ^ in_data;
`endif
            state     <= WRITE;
          end
        end
        WRITE: begin
          mem_we     <= 1'b0;
          word_count <= word_count + 1'b1;
          if ({1'b0, idx} == n - 1'b1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state <= CHK;
`else
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
`endif
          end else begin
            idx   <= idx + 1'b1;
            state <= HI;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (xfer) begin
            busy <= 1'b0;
            if (in_data == csum) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state  <= IDLE;
          mem_we <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader; frame-level reference model, negedge write monitor.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, mem_we, busy, done, error;
  logic [3:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [4:0]  word_count;

  imem_loader #(.WORD_W(16), .DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] a; logic [15:0] d; } wr_t;
  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [15:0] fw[$];
  int          n_checks = 0, n_pass = 0, xfers = 0;
  logic        prev_we = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: every write pulse must match the next expected (addr, data).
  always @(negedge clk) begin
    if (in_valid && in_ready) xfers++;
    if (mem_we === 1'b1) begin
      chk("we_pulse_width", 32'(prev_we), 0);
      if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(mon_e.a));
        chk("wr_data", 32'(mem_wdata), 32'(mon_e.d));
      end
    end
    prev_we = mem_we;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    repeat (gap) tick();
    in_valid = 1'b1; in_data = b;
    while (!in_ready && t < 200) begin tick(); t++; end
    if (t >= 200) chk("ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string nm);
    chk({nm, "_ctl"}, 32'({in_ready, mem_we, busy, done, error}), 0);
    chk({nm, "_addr_data"}, 32'({mem_addr, mem_wdata}), 0);
    chk({nm, "_word_count"}, 32'(word_count), 0);
  endtask

  // Reference model works on the whole frame: header validity, expected writes,
  // XOR of word bytes, bytes consumed and cycles from last byte to completion.
  task automatic do_frame(input logic [7:0] hdr, input int gap, input int stall, input bit good_ck);
    logic [7:0] ck = 8'h00;
    logic [7:0] ckb;
    bit bad, exp_err;
    int n, consumed, lat, xf0, t;
    bad = (hdr == 0) || (hdr > 16);
    n = bad ? 0 : int'(hdr);
    consumed = 1 + 2 * n;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{4'(i), fw[i]});
      ck ^= fw[i][15:8] ^ fw[i][7:0];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    ckb = good_ck ? ck : ((ck == 8'h00) ? 8'hFF : 8'h00);
    if (!bad) consumed++;
    exp_err = bad || !good_ck;
    lat = 0;
`else
    ckb = 8'h00;
    exp_err = bad;
    lat = bad ? 0 : 1;
`endif
    xf0 = xfers;
    pulse_start();
    chk("busy_after_start", 32'({busy, done, error}), 3'b100);
    send_byte(hdr, gap);
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (stall) tick();
      send_byte(fw[i][15:8], gap);
      send_byte(fw[i][7:0], gap);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (!bad) send_byte(ckb, gap);
`else
    if (ckb != 8'h00) chk("ck_unused", 32'(ckb), 0);
`endif
    t = 0;
    while (busy && t < 200) begin tick(); t++; end
    chk("completion_latency", t, lat);
    chk("done", 32'(done), 32'(!exp_err));
    chk("error", 32'(error), 32'(exp_err));
    chk("word_count", 32'(word_count), n);
    chk("writes_outstanding", exp_q.size(), 0);
    chk("bytes_consumed", xfers - xf0, consumed);
    chk("in_ready_after", 32'(in_ready), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int xf0;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) tick();
    start = 1'b1; tick();            // start with reset asserted must lose
    reset = 1'b0; start = 1'b0;
    check_idle_outputs("reset");

    // 1: two-word frame, back-to-back bytes
    fw = '{16'h1234, 16'hABCD};
    do_frame(8'h02, 0, 0, 1'b1);
`ifndef IMEM_LOADER_CHECKSUM_EN
    xf0 = xfers;
    in_valid = 1'b1; in_data = 8'h55;
    repeat (3) begin tick(); chk("extra_byte_ready", 32'(in_ready), 0); end
    in_valid = 1'b0;
    chk("extra_byte_not_taken", xfers - xf0, 0);
`endif

    // 2: invalid headers
    fw = {};
    do_frame(8'h00, 0, 0, 1'b1);
    do_frame(8'h11, 0, 0, 1'b1);

    // 3: toggling valid, stall between words, stray start mid-load
    fw = '{16'h0001, 16'h0002, 16'h0003};
    fork
      do_frame(8'h03, 1, 5, 1'b1);
      begin repeat (8) tick(); start = 1'b1; tick(); start = 1'b0; end
    join

    // 4: reset after first word of an N=4 load
    exp_q.push_back('{4'h0, 16'h1122});
    pulse_start();
    send_byte(8'h04, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
    reset = 1'b1; tick(); reset = 1'b0;
    check_idle_outputs("midload_reset");
    chk("midload_write_seen", exp_q.size(), 0);
    fw = '{16'hBEEF};
    do_frame(8'h01, 0, 0, 1'b1);

    // 5: full-depth load
    fw = {};
    for (int i = 0; i < 16; i++) fw.push_back(16'hF000 + 16'(i));
    do_frame(8'h10, 0, 0, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // 6: checksum good (0x26) then bad (0x00)
    fw = '{16'h1234};
    do_frame(8'h01, 0, 0, 1'b1);
    do_frame(8'h01, 0, 0, 1'b0);
`endif

    // random frames
    for (int k = 0; k < 10; k++) begin
      logic [7:0] h;
      fw = {};
      if ($urandom_range(0, 3) == 0) h = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255));
      else h = 8'($urandom_range(1, 16));
      for (int i = 0; i < 16; i++) fw.push_back(16'($urandom));
      do_frame(h, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
